issue_scoreboard_param: RTL

- Parametrised successor to the single-scoreboard issue stage. Sits between decode and the functional units.
- Holds a per-register pending scoreboard and a result-bus reservation shift register.
- Issues at most one instruction per cycle to one of NUNITS pipelined functional units.
- Stalls decode on RAW, WAW and result-bus hazards, forwards same-cycle writeback data, and counts stall cycles.

---
 rtl/issue_scoreboard_param_if.sv | 51 +++++
 rtl/issue_scoreboard_param.sv | 110 +++++++++++
 2 files changed

// File: rtl/issue_scoreboard_param_if.sv
// Decode/regfile/writeback/execute signal bundle for the parametrised issue stage.
// The master side is decode plus its environment; the slave side is the issue stage.
interface issue_scoreboard_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int UNIT_W = 2,
    parameter int NUNITS = 3,
    parameter int CTRL_W = 16
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_srca;
    logic [ADDR_W-1:0] id_srcb;
    logic              id_usesb;
    logic [ADDR_W-1:0] id_dest;
    logic              id_writereg;
    logic [UNIT_W-1:0] id_unit;
    logic [DATA_W-1:0] id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [ADDR_W-1:0] rf_addra;
    logic [ADDR_W-1:0] rf_addrb;
    logic [DATA_W-1:0] rf_dataa;
    logic [DATA_W-1:0] rf_datab;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              iss_stall;
    logic              ex_valid;
    logic [NUNITS-1:0] ex_unit;
    logic [DATA_W-1:0] ex_rega;
    logic [DATA_W-1:0] ex_regb;
    logic [DATA_W-1:0] ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [ADDR_W-1:0] ex_dest;
    logic              ex_writereg;
    logic [15:0]       stall_cnt;

    modport master (
        output id_valid, id_srca, id_srcb, id_usesb, id_dest, id_writereg, id_unit,
               id_imm, id_ctrl, rf_dataa, rf_datab, wb_valid, wb_addr, wb_data, flush,
        input  rf_addra, rf_addrb, iss_stall, ex_valid, ex_unit, ex_rega, ex_regb,
               ex_imm, ex_ctrl, ex_dest, ex_writereg, stall_cnt
    );

    modport slave (
        input  id_valid, id_srca, id_srcb, id_usesb, id_dest, id_writereg, id_unit,
               id_imm, id_ctrl, rf_dataa, rf_datab, wb_valid, wb_addr, wb_data, flush,
        output rf_addra, rf_addrb, iss_stall, ex_valid, ex_unit, ex_rega, ex_regb,
               ex_imm, ex_ctrl, ex_dest, ex_writereg, stall_cnt
    );
endinterface

// File: rtl/issue_scoreboard_param.sv
// Single-issue stage with per-register pending scoreboard and result-bus reservation.
// Stalls decode on RAW/WAW/bus hazards, forwards same-cycle writeback, counts stall cycles.
module issue_scoreboard_param #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int NUNITS = 3,
    parameter int UNIT_W = 2,
    parameter int LAT_W  = 3,
    parameter logic [NUNITS*LAT_W-1:0] UNIT_LAT = {3'd4, 3'd2, 3'd1},
    parameter int CTRL_W = 16
) (
    input logic clock,
    input logic reset,
    issue_scoreboard_param_if.slave bus
);
    localparam int MAX_LAT = 2**LAT_W - 1;
    localparam int RES_W   = MAX_LAT + 1;

    logic [NREG-1:0]   pending;
    logic [RES_W-1:0]  res;
    logic [NREG-1:0]   wb_clr;
    logic [NREG-1:0]   pend_eff;
    logic [NREG-1:0]   pend_set;
    logic [LAT_W-1:0]  lat;
    logic [RES_W-1:0]  res_set;
    logic [NUNITS-1:0] onehot;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic raw, waw, bus_hz, illegal, stall, issue;

    function automatic logic [LAT_W-1:0] unit_lat(input logic [UNIT_W-1:0] u);
        unit_lat = '0;
        for (int i = 0; i < NUNITS; i++)
            if (u == UNIT_W'(i)) unit_lat = UNIT_LAT[i*LAT_W +: LAT_W];
    endfunction

    function automatic logic [DATA_W-1:0] operand(
        input logic [ADDR_W-1:0] src, input logic [DATA_W-1:0] rf,
        input logic wbv, input logic [ADDR_W-1:0] wba, input logic [DATA_W-1:0] wbd);
        if (src == '0)                   operand = '0;
        else if (wbv && wba == src)      operand = wbd;
        else                             operand = rf;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign bus.rf_addra = bus.id_srca;
    assign bus.rf_addrb = bus.id_srcb;

    // A writeback landing this cycle already resolves its register's hazard.
    always_comb begin
        wb_clr = '0;
        if (bus.wb_valid && bus.wb_addr != '0) wb_clr[bus.wb_addr] = 1'b1;
    end
    assign pend_eff = pending & ~wb_clr;

    assign lat     = unit_lat(bus.id_unit);
    assign illegal = (int'(bus.id_unit) >= NUNITS);
    assign raw     = (bus.id_srca != '0 && pend_eff[bus.id_srca]) ||
                     (bus.id_usesb && bus.id_srcb != '0 && pend_eff[bus.id_srcb]);
    assign waw     = bus.id_writereg && bus.id_dest != '0 && pend_eff[bus.id_dest];
    assign bus_hz  = bus.id_writereg && res[lat];
    assign stall   = bus.id_valid && (raw || waw || bus_hz || illegal);
    assign issue   = bus.id_valid && !stall && !bus.flush;
    assign bus.iss_stall = stall;

    assign onehot  = NUNITS'(1) << bus.id_unit;
    assign res_set = (issue && bus.id_writereg) ? (RES_W'(1) << LAT_W'(lat - LAT_W'(1))) : '0;
    assign opa     = operand(bus.id_srca, bus.rf_dataa, bus.wb_valid, bus.wb_addr, bus.wb_data);
    assign opb     = operand(bus.id_srcb, bus.rf_datab, bus.wb_valid, bus.wb_addr, bus.wb_data);

    always_comb begin
        pend_set = '0;
        if (issue && bus.id_writereg && bus.id_dest != '0) pend_set[bus.id_dest] = 1'b1;
    end

    // Issue register: control clears when nothing issues, operand fields hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_unit     <= '0;
            bus.ex_rega     <= '0;
            bus.ex_regb     <= '0;
            bus.ex_imm      <= '0;
            bus.ex_ctrl     <= '0;
            bus.ex_dest     <= '0;
            bus.ex_writereg <= 1'b0;
            bus.stall_cnt   <= '0;
            pending         <= '0;
            res             <= '0;
        end else begin
            bus.ex_valid <= issue;
            bus.ex_unit  <= issue ? onehot : '0;
            if (issue) begin
                bus.ex_rega     <= opa;
                bus.ex_regb     <= opb;
                bus.ex_imm      <= bus.id_imm;
                bus.ex_ctrl     <= bus.id_ctrl;
                bus.ex_dest     <= bus.id_dest;
                bus.ex_writereg <= bus.id_writereg;
            end
            pending <= pend_eff | pend_set;
            res     <= (res >> 1) | res_set;
            if (stall) bus.stall_cnt <= sat_inc(bus.stall_cnt);
        end
    end
endmodule
